// File: rtl/ts_clk_pkg.sv
// Shared types and constants for the ts_clk_gen tick/clock generator.
package ts_clk_pkg;

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam logic [1:0] MUX_ANY = 2'b00;
   localparam logic [1:0] MUX_ALL = 2'b01;
   localparam logic [1:0] MUX_ON  = 2'b10;
   localparam logic [1:0] MUX_OFF = 2'b11;

   // round(2^24 * 54 / 100): 54 MHz wrap rate from a 100 MHz clock at ACC_W=24
   localparam int unsigned INC_54M_100M = 32'd9059697;

   function automatic logic mux_en(input logic [1:0] mode, input logic any_v, input logic all_v);
      logic en;
      en = 1'b0;
      case (mode)
         MUX_ANY: en = any_v;
         MUX_ALL: en = all_v;
         MUX_ON:  en = 1'b1;
         default: en = 1'b0;
      endcase
      return en;
   endfunction

endpackage

// File: rtl/ts_phase_acc.sv
// Phase accumulator with increment register, one-deep pending increment and
// ready/valid config handshake; flags the carry-out of acc + inc as wrap.
module ts_phase_acc #(
   parameter int          ACC_W   = 24,
   parameter int unsigned INC_RST = 32'd9059697
) (
   input  logic             clk2,
   input  logic             rst_n,
   input  logic             active,
   input  logic             cfg_valid,
   input  logic [ACC_W-1:0] cfg_inc,
   output logic             cfg_ready,
   output logic             wrap
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] inc_q, inc_d;
   logic [ACC_W-1:0] pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic [ACC_W-1:0] sum;
   logic             carry;

   always_comb begin
      {carry, sum} = {1'b0, acc_q} + {1'b0, inc_q};
      wrap         = active & carry;
      cfg_ready    = ~pend_vld_q;
      acc_d        = active ? sum : acc_q;
      inc_d        = inc_q;
      pend_d       = pend_q;
      pend_vld_d   = pend_vld_q;
      // Swap on a wrap boundary so the interval in flight keeps its length;
      // a value captured on the wrap cycle itself waits for the next wrap.
      if (pend_vld_q && (wrap || !active)) begin
         inc_d      = pend_q;
         pend_vld_d = 1'b0;
      end
      if (cfg_valid && cfg_ready) begin
         pend_d     = cfg_inc;
         pend_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk2) begin
      if (!rst_n) begin
         acc_q      <= '0;
         inc_q      <= ACC_W'(INC_RST);
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         inc_q      <= inc_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
      end
   end

endmodule

// File: rtl/ts_clk_gen.sv
// Enable-gated DDS tick generator: registered tick pulse per accumulator wrap and
// a divided clk_out. Define TS_CLK_GEN_TICK_CNT_EN to add the 32-bit tick_cnt output.
module ts_clk_gen
   import ts_clk_pkg::*;
#(
   parameter int          NUM_CH      = 4,
   parameter int          ACC_W       = 24,
   parameter int unsigned INC_DEFAULT = INC_54M_100M
) (
   input  logic              clk2,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] valid,
   input  logic [1:0]        mux_ctrl,
   input  logic              cfg_valid,
   input  logic [ACC_W-1:0]  cfg_inc,
   output logic              cfg_ready,
   output logic              tick,
   output logic              clk_out,
   output logic              running
`ifdef TS_CLK_GEN_TICK_CNT_EN
   ,
   output logic [31:0]       tick_cnt
`endif
);

   state_e state_q, state_d;
   logic   tick_q, tick_d;
   logic   clk_out_q, clk_out_d;
   logic   running_q, running_d;
   logic   en;
   logic   active;
   logic   wrap;

   ts_phase_acc #(
      .ACC_W   (ACC_W),
      .INC_RST (INC_DEFAULT)
   ) u_acc (
      .clk2      (clk2),
      .rst_n     (rst_n),
      .active    (active),
      .cfg_valid (cfg_valid),
      .cfg_inc   (cfg_inc),
      .cfg_ready (cfg_ready),
      .wrap      (wrap)
   );

   always_comb begin
      en        = mux_en(mux_ctrl, |valid, &valid);
      active    = (state_q != ST_STOP);
      tick_d    = wrap;
      clk_out_d = clk_out_q ^ wrap;
      state_d   = state_q;
      // Stopping uses the post-edge clk_out level so clk_out is always low in STOP.
      case (state_q)
         ST_STOP:  if (en) state_d = ST_RUN;
         ST_RUN:   if (!en) state_d = clk_out_d ? ST_DRAIN : ST_STOP;
         ST_DRAIN: begin
            if (en)              state_d = ST_RUN;
            else if (!clk_out_d) state_d = ST_STOP;
         end
         default:  state_d = ST_STOP;
      endcase
      running_d = (state_d != ST_STOP);
   end

   always_ff @(posedge clk2) begin
      if (!rst_n) begin
         state_q   <= ST_STOP;
         tick_q    <= 1'b0;
         clk_out_q <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         clk_out_q <= clk_out_d;
         running_q <= running_d;
      end
   end

   assign tick    = tick_q;
   assign clk_out = clk_out_q;
   assign running = running_q;

`ifdef TS_CLK_GEN_TICK_CNT_EN
   logic [31:0] tick_cnt_q, tick_cnt_d;

   always_comb tick_cnt_d = tick_q ? tick_cnt_q + 32'd1 : tick_cnt_q;

   always_ff @(posedge clk2) begin
      if (!rst_n) tick_cnt_q <= '0;
      else        tick_cnt_q <= tick_cnt_d;
   end

   assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_ts_clk_gen.sv
// Directed self-checking bench for ts_clk_gen with hand-computed expectations.
module tb_ts_clk_gen;
   import ts_clk_pkg::*;

   localparam int ACC_W = 24;
   localparam logic [ACC_W-1:0] I23 = 24'h800000;
   localparam logic [ACC_W-1:0] I22 = 24'h400000;
   localparam logic [ACC_W-1:0] I21 = 24'h200000;
   localparam logic [ACC_W-1:0] I20 = 24'h100000;

   logic             clk2 = 1'b0;
   logic             rst_n = 1'b0;
   logic [3:0]       valid = '0;
   logic [1:0]       mux_ctrl = MUX_OFF;
   logic             cfg_valid = 1'b0;
   logic [ACC_W-1:0] cfg_inc = '0;
   logic             cfg_ready, tick, clk_out, running;
`ifdef TS_CLK_GEN_TICK_CNT_EN
   logic [31:0]      tick_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   ts_clk_gen #(.NUM_CH(4), .ACC_W(ACC_W), .INC_DEFAULT(9059697)) u_dut (
      .clk2      (clk2),
      .rst_n     (rst_n),
      .valid     (valid),
      .mux_ctrl  (mux_ctrl),
      .cfg_valid (cfg_valid),
      .cfg_inc   (cfg_inc),
      .cfg_ready (cfg_ready),
      .tick      (tick),
      .clk_out   (clk_out),
      .running   (running)
`ifdef TS_CLK_GEN_TICK_CNT_EN
      ,
      .tick_cnt  (tick_cnt)
`endif
   );

   always #5 clk2 = ~clk2;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk2);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; mux_ctrl = MUX_OFF; cfg_valid = 1'b0; valid = '0;
      step(); step();
      rst_n = 1'b1;
   endtask

   // Loads an increment while stopped: capture edge, then apply edge.
   task automatic set_inc(input logic [ACC_W-1:0] v);
      cfg_valid = 1'b1; cfg_inc = v;
      step();
      cfg_valid = 1'b0;
      step();
   endtask

   logic [63:0] tv, cv, rv;
   int          nt, nr;
   logic        prev_clk;

   initial begin
      // Reset state
      do_reset();
      chk("rst_tick", tick, 0);
      chk("rst_clk_out", clk_out, 0);
      chk("rst_running", running, 0);
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_inc", u_dut.u_acc.inc_q, 24'd9059697);
      chk("rst_acc", u_dut.u_acc.acc_q, 0);

      // inc=2^23, always on: tick every 2 cycles, clk_out period 4
      set_inc(I23);
      tv = '0; cv = '0;
      for (int k = 1; k <= 16; k++) begin
         if (k == 1) mux_ctrl = MUX_ON;
         step();
         tv[k-1] = tick; cv[k-1] = clk_out;
      end
      chk("s1_tick_vec", tv, 64'h5554);
      chk("s1_clk_vec", cv, 64'hCCCC);
      chk("s1_running", running, 1);

      // inc=2^22, any-valid with one channel, then all-valid -> STOP
      do_reset();
      set_inc(I22);
      valid = 4'b0001;
      tv = '0; cv = '0;
      for (int k = 1; k <= 10; k++) begin
         if (k == 1) mux_ctrl = MUX_ANY;
         step();
         tv[k-1] = tick; cv[k-1] = clk_out;
      end
      chk("s2_tick_vec", tv, 64'h110);
      chk("s2_clk_vec", cv, 64'h0F0);
      tv = '0; cv = '0; rv = '0;
      for (int k = 1; k <= 8; k++) begin
         if (k == 1) mux_ctrl = MUX_ALL;
         step();
         tv[k-1] = tick; cv[k-1] = clk_out; rv[k-1] = running;
      end
      chk("s2_stop_tick", tv, 0);
      chk("s2_stop_clk", cv, 0);
      chk("s2_stop_running", rv, 0);
      chk("s2_acc_frozen", u_dut.u_acc.acc_q, 24'h800000);
      chk("s2_state", u_dut.state_q, ST_STOP);

      // inc=0 never ticks
      do_reset();
      set_inc('0);
      tv = '0;
      for (int k = 1; k <= 12; k++) begin
         if (k == 1) mux_ctrl = MUX_ON;
         step();
         tv[k-1] = tick;
      end
      chk("inc0_no_tick", tv, 0);

      // Default increment over 10000 cycles
      do_reset();
      nt = 0; nr = 0; prev_clk = 1'b0;
      mux_ctrl = MUX_ON;
      for (int k = 0; k < 10000; k++) begin
         step();
         if (tick) nt++;
         if (clk_out && !prev_clk) nr++;
         prev_clk = clk_out;
      end
      chk("s3_ticks_5400pm1", (nt >= 5399 && nt <= 5401) ? 64'(nt) : 64'hBAD0_0000 | 64'(nt), 64'(nt));
      chk("s3_periods_2700pm1", (nr >= 2699 && nr <= 2701) ? 64'(nr) : 64'hBAD0_0000 | 64'(nr), 64'(nr));
`ifdef TS_CLK_GEN_TICK_CNT_EN
      chk("s3_tick_cnt", tick_cnt, 64'(nt));
`endif

      // en dropped while clk_out=1 -> DRAIN, clk_out falls on next tick -> STOP
      do_reset();
      set_inc(I22);
      for (int k = 1; k <= 14; k++) begin
         if (k == 1) mux_ctrl = MUX_ON;
         step();
      end
      chk("s4_pre_clk", clk_out, 1);
      mux_ctrl = MUX_OFF;
      step();
      chk("s4_drain_state", u_dut.state_q, ST_DRAIN);
      chk("s4_drain_running", running, 1);
      chk("s4_drain_clk", clk_out, 1);
      step();
      chk("s4_drain2_tick", tick, 0);
      step();
      chk("s4_fall_tick", tick, 1);
      chk("s4_fall_clk", clk_out, 0);
      chk("s4_stop_state", u_dut.state_q, ST_STOP);
      chk("s4_stop_running", running, 0);
      step();
      chk("s4_after_tick", tick, 0);

      // Increment change mid-RUN, with a second offer held off until ready
      do_reset();
      set_inc(I22);
      tv = '0; rv = '0;
      for (int k = 1; k <= 40; k++) begin
         if (k == 1) mux_ctrl = MUX_ON;
         if (k == 7) begin cfg_valid = 1'b1; cfg_inc = I21; end
         if (k == 8) cfg_inc = I20;
         if (k == 11) cfg_valid = 1'b0;
         step();
         tv[k-1] = tick; rv[k-1] = cfg_ready;
      end
      chk("s5_tick_vec", tv, 64'h0000_0001_0001_0110);
      chk("s5_ready_vec", rv, 64'h0000_00FF_FFFF_013F);
      chk("s5_final_inc", u_dut.u_acc.inc_q, I20);

      // Reset mid-DRAIN with a pending increment
      do_reset();
      set_inc(I22);
      for (int k = 1; k <= 14; k++) begin
         if (k == 1) mux_ctrl = MUX_ON;
         step();
      end
      mux_ctrl = MUX_OFF;
      step();
      chk("s6_drain_state", u_dut.state_q, ST_DRAIN);
      cfg_valid = 1'b1; cfg_inc = I21;
      step();
      chk("s6_pending_ready", cfg_ready, 0);
      cfg_valid = 1'b0;
      rst_n = 1'b0;
      step();
      chk("s6_rst_tick", tick, 0);
      chk("s6_rst_clk", clk_out, 0);
      chk("s6_rst_running", running, 0);
      chk("s6_rst_ready", cfg_ready, 1);
      chk("s6_rst_state", u_dut.state_q, ST_STOP);
      chk("s6_rst_acc", u_dut.u_acc.acc_q, 0);
      chk("s6_rst_inc", u_dut.u_acc.inc_q, 24'd9059697);
`ifdef TS_CLK_GEN_TICK_CNT_EN
      chk("s6_rst_tick_cnt", tick_cnt, 0);
`endif
      rst_n = 1'b1;
      step(); step();
      chk("s6_pending_dropped", u_dut.u_acc.inc_q, 24'd9059697);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ts_clk_gen.md
TS_CLK_GEN -- requirements
Module: ts_clk_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of channel valid inputs.
REQ-002 Parameter ACC_W, default 24: phase accumulator width, in bits.
REQ-003 Parameter INC_DEFAULT, default 9059697: increment after reset, giving a 54 MHz tick and a 27 MHz clk_out from 100 MHz.
REQ-004 clk2  in  1  single clock; all logic is rising-edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 valid  in  NUM_CH  per-channel activity flags.
REQ-007 mux_ctrl  in  2  enable mode: 00 any valid, 01 all valid, 10 always on, 11 off.
REQ-008 cfg_valid  in  1  new increment offered.
REQ-009 cfg_inc  in  ACC_W  offered increment.
REQ-010 cfg_ready  out  1  increment slot free.
REQ-011 tick  out  1  one-cycle clock-enable pulse.
REQ-012 clk_out  out  1  divided clock, toggles on each tick.
REQ-013 running  out  1  high in RUN or DRAIN.

Function
REQ-014 en SHALL equal |valid, &valid, 1 or 0 for mux_ctrl 00, 01, 10 or 11, evaluated combinationally each cycle.
REQ-015 FSM states SHALL be STOP, RUN and DRAIN.
REQ-016 Transitions:
- STOP to RUN when en=1.
- RUN to DRAIN when en=0 and clk_out=1.
- RUN to STOP when en=0 and clk_out=0.
- DRAIN to RUN when en=1.
- DRAIN to STOP on the tick that drives clk_out to 0.
REQ-017 In RUN or DRAIN, acc SHALL update as acc <= acc + inc modulo 2^ACC_W each cycle; carry-out is the wrap event.
REQ-018 In STOP, acc SHALL hold its value; tick SHALL be 0.
REQ-019 tick SHALL be registered, asserting the cycle after a wrap, for exactly one cycle per wrap.
REQ-020 clk_out SHALL invert in the same cycle tick is 1, and SHALL hold otherwise.
REQ-021 inc=0 SHALL produce no ticks; a DRAIN state entered with inc=0 SHALL remain until en returns or reset.
REQ-022 cfg_ready SHALL be 1 when no increment is pending; a cfg_valid&cfg_ready cycle captures cfg_inc into pending and drops cfg_ready next cycle.
REQ-023 In RUN or DRAIN, pending SHALL become inc on the first wrap after capture, with no tick lost or added; in STOP it SHALL apply on the next cycle; cfg_ready then rises again.
REQ-024 cfg_valid while cfg_ready=0 SHALL be ignored; the offer holds until accepted.
REQ-025 If capture and a wrap coincide, the captured value SHALL apply at the following wrap.
REQ-026 running SHALL be registered from the FSM state.

Reset
REQ-027 While rst_n=0 at a clk2 edge, the following SHALL load: state=STOP, acc=0, inc=INC_DEFAULT, pending cleared, cfg_ready=1, tick=0, clk_out=0, running=0.
REQ-028 Reset mid-RUN or mid-DRAIN SHALL discard any pending increment and abandon the current clk_out phase with no extra tick.

Configuration
REQ-029 With macro TS_CLK_GEN_TICK_CNT_EN defined: output tick_cnt (32 bits) SHALL count ticks, wrap at 2^32, and reset to 0.
REQ-030 Without TS_CLK_GEN_TICK_CNT_EN: tick_cnt port and counter SHALL be absent; all other behaviour is unchanged.

Structure
REQ-031 Package ts_clk_pkg SHALL hold:
- the FSM state typedef;
- the mux_ctrl mode encodings;
- the 54 MHz/100 MHz increment constant for ACC_W=24.
REQ-032 Sub-module ts_phase_acc SHALL hold the accumulator, the increment register, the pending register with its cfg handshake, and wrap detection; the FSM, tick and clk_out stay in ts_clk_gen.

Verification
REQ-033 The bench SHALL cover these directed scenarios (ACC_W=24):
- inc=2^23, mux_ctrl=10 -> tick every 2 cycles; clk_out period 4 cycles, 50% duty.
- inc=2^22, valid=0001, mux_ctrl=00 -> tick every 4 cycles; mux_ctrl=01 -> STOP, acc frozen.
- Default inc over 10000 cycles -> 5400 +/- 1 ticks and 2700 +/- 1 clk_out periods.
- en dropped while clk_out=1 at inc=2^22 -> DRAIN; clk_out falls on the next tick; state STOP; running=0.
- cfg_inc=2^21 accepted mid-RUN at inc=2^22 -> current 4-cycle interval completes, then 8-cycle intervals; cfg_ready low until applied; a second offer meanwhile is held.
- rst_n=0 mid-DRAIN with a pending increment -> all outputs at reset values next cycle; inc=INC_DEFAULT; tick_cnt=0 when the macro is defined.
